// File: rtl/weather_pkg.sv
// Shared types and constants for the weather-station serial transmitter.
// Frame bit levels, the data width and the transmitter FSM encoding live here.
package weather_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_W    = 8;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/weather_uart_tx_if.sv
// Bundle between the detector stage and the UART transmitter.
// The transmitter is the slave: it takes the reading and drives the line status.
interface weather_uart_tx_if;
    import weather_pkg::*;

    logic [UART_DATA_W-1:0] din;
    logic                   tx;
    logic                   busy;
    logic                   frame_done;
    logic                   overrun;

    modport master (
        output din,
        input  tx,
        input  busy,
        input  frame_done,
        input  overrun
    );

    modport slave (
        input  din,
        output tx,
        output busy,
        output frame_done,
        output overrun
    );

endinterface

// File: rtl/weather_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// A synchronous clear restarts the period so every state begins on a full bit.
module weather_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last    = (r_cnt == CNT_LAST);
    assign o_bit_end = w_last;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/weather_uart_tx.sv
// Sends each new detector reading as one UART frame, LSB first, optional even parity.
// A one-deep pending slot absorbs readings that arrive while a frame is on the line.
//
//   state  | meaning
//   IDLE   | line high, waiting for a pending reading
//   START  | start bit (low) for one bit period
//   DATA   | eight data bits, LSB first
//   PARITY | even-parity bit (only when PARITY_EN)
//   STOP   | stop bit (high); then next pending frame or IDLE
module weather_uart_tx
    import weather_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input logic              CLK,
    input logic              Reset_n,
    weather_uart_tx_if.slave bus
);

    uart_state_t            r_state;
    logic [UART_DATA_W-1:0] r_prev_din;
    logic [UART_DATA_W-1:0] r_pend;
    logic                   r_pend_v;
    logic [UART_DATA_W-1:0] r_shreg;
    logic                   r_parity;
    logic [2:0]             r_bit_idx;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_frame_done;
    logic                   r_overrun;

    logic                   w_bit_end;
    logic                   w_baud_clr;
    logic                   w_change;
    logic                   w_consume;

    // Held at zero while idle so the start bit always gets a full period.
    assign w_baud_clr = (r_state == IDLE) || w_bit_end;

    weather_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .i_clear   (w_baud_clr),
        .o_bit_end (w_bit_end)
    );

    assign w_change  = (bus.din != r_prev_din);
    assign w_consume = r_pend_v &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_prev_din   <= '0;
            r_pend       <= '0;
            r_pend_v     <= 1'b0;
            r_shreg      <= '0;
            r_parity     <= 1'b0;
            r_bit_idx    <= '0;
            r_tx         <= UART_STOP_BIT;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_prev_din   <= bus.din;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;

            // A fresh reading wins over a same-edge consume: the slot stays full.
            if (w_change) begin
                r_pend    <= bus.din;
                r_pend_v  <= 1'b1;
                r_overrun <= r_pend_v && !w_consume;
            end else if (w_consume) begin
                r_pend_v  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_pend_v) begin
                        r_state  <= START;
                        r_shreg  <= r_pend;
                        r_parity <= even_parity(r_pend);
                        r_tx     <= UART_START_BIT;
                        r_busy   <= 1'b1;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_tx      <= r_shreg[0];
                        r_bit_idx <= '0;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                r_state <= PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= UART_STOP_BIT;
                            end
                        end else begin
                            r_tx      <= r_shreg[1];
                            r_shreg   <= r_shreg >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_tx    <= UART_STOP_BIT;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        r_frame_done <= 1'b1;
                        if (r_pend_v) begin
                            r_state  <= START;
                            r_shreg  <= r_pend;
                            r_parity <= even_parity(r_pend);
                            r_tx     <= UART_START_BIT;
                        end else begin
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= UART_STOP_BIT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_weather_uart_tx.sv
// Bench for weather_uart_tx: two instances (no parity / even parity) share one reading.
// A frame-level model predicts which readings go out and when; a line decoder checks them.
module tb_weather_uart_tx;
    import weather_pkg::*;

    localparam int C = 4;

    logic       CLK     = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] tb_din  = 8'h00;

    always #5 CLK = ~CLK;

    weather_uart_tx_if if0 ();
    weather_uart_tx_if if1 ();

    assign if0.din = tb_din;
    assign if1.din = tb_din;

    weather_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut0 (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (if0.slave)
    );

    weather_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut1 (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (if1.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h want %0h", name, d, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic qpush(input int d, input logic [7:0] v, input int s);
        exp_t e;
        e.data  = v;
        e.start = s;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Frame-level reference: a frame occupies the line for L cycles from its start edge;
    // the pending slot holds the newest unsent reading.
    int         n = 0;
    logic [7:0] m_prev = 8'h00;
    bit         m_active [2];
    bit         m_pv     [2];
    logic [7:0] m_pend   [2];
    int         m_end    [2];
    bit         m_fd     [2];
    bit         m_ovr    [2];
    int         m_len;
    bit         m_cons;
    bit         m_chg;

    always @(posedge CLK) begin
        n++;
        if (!Reset_n) begin
            m_prev = 8'h00;
            for (int d = 0; d < 2; d++) begin
                m_active[d] = 1'b0;
                m_pv[d]     = 1'b0;
                m_fd[d]     = 1'b0;
                m_ovr[d]    = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            m_chg = (tb_din != m_prev);
            for (int d = 0; d < 2; d++) begin
                m_len  = (d == 0) ? 10 * C : 11 * C;
                m_cons = 1'b0;
                m_fd[d]  = 1'b0;
                m_ovr[d] = 1'b0;
                if (m_active[d] && n == m_end[d]) begin
                    m_fd[d] = 1'b1;
                    if (m_pv[d]) begin
                        m_cons   = 1'b1;
                        qpush(d, m_pend[d], n);
                        m_end[d] = n + m_len;
                    end else begin
                        m_active[d] = 1'b0;
                    end
                end else if (!m_active[d] && m_pv[d]) begin
                    m_cons      = 1'b1;
                    qpush(d, m_pend[d], n);
                    m_active[d] = 1'b1;
                    m_end[d]    = n + m_len;
                end
                if (m_chg) begin
                    m_ovr[d]  = m_pv[d] && !m_cons;
                    m_pend[d] = tb_din;
                    m_pv[d]   = 1'b1;
                end else if (m_cons) begin
                    m_pv[d] = 1'b0;
                end
            end
            m_prev = tb_din;
        end
    end

    // Line decoder / scoreboard consumer: samples each bit mid-period on the falling edge.
    bit          dec   [2];
    int          t0    [2];
    logic [10:0] word  [2];
    logic        o_tx, o_busy, o_fd, o_ovr;
    int          off, slot, nslots;
    exp_t        e_pop;

    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            o_tx   = (d == 0) ? if0.tx         : if1.tx;
            o_busy = (d == 0) ? if0.busy       : if1.busy;
            o_fd   = (d == 0) ? if0.frame_done : if1.frame_done;
            o_ovr  = (d == 0) ? if0.overrun    : if1.overrun;
            nslots = (d == 0) ? 10 : 11;

            check("busy", d, 32'(o_busy), 32'(m_active[d]));
            check("frame_done", d, 32'(o_fd), 32'(m_fd[d]));
            check("overrun", d, 32'(o_ovr), 32'(m_ovr[d]));
            if (!m_active[d]) check("idle_tx_high", d, 32'(o_tx), 32'd1);

            if (!Reset_n) begin
                dec[d] = 1'b0;
            end else if (!dec[d]) begin
                if (o_tx == 1'b0) begin
                    dec[d]  = 1'b1;
                    t0[d]   = n;
                    word[d] = '0;
                end
            end else begin
                off = n - t0[d];
                if (off % C == C / 2) begin
                    slot = off / C;
                    word[d][slot] = o_tx;
                    if (slot == nslots - 1) begin
                        dec[d] = 1'b0;
                        check("frame_expected", d, 32'(qsize(d) != 0), 32'd1);
                        if (qsize(d) != 0) begin
                            e_pop = qpop(d);
                            check("start_cycle", d, 32'(t0[d]), 32'(e_pop.start));
                            check("start_bit", d, 32'(word[d][0]), 32'(UART_START_BIT));
                            check("data", d, 32'(word[d][8:1]), 32'(e_pop.data));
                            if (d == 1)
                                check("parity", d, 32'(word[d][9]), 32'(^e_pop.data));
                            check("stop_bit", d, 32'(word[d][nslots-1]), 32'(UART_STOP_BIT));
                        end
                    end
                end
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge CLK);
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (waited < 3000) begin
            @(negedge CLK);
            waited++;
            if (!m_active[0] && !m_active[1] && !m_pv[0] && !m_pv[1]) break;
        end
        check("idle_reached", 0, 32'(waited < 3000), 32'd1);
        cycles(3);
    endtask

    task automatic wait_cycle_no(input int target);
        int waited;
        waited = 0;
        while (n != target && waited < 500) begin
            @(negedge CLK);
            waited++;
        end
        check("cycle_reached", 0, 32'(n == target), 32'd1);
    endtask

    initial begin
        tb_din  = 8'h00;
        Reset_n = 1'b0;
        cycles(3);
        #2 Reset_n = 1'b1;

        // quiet after reset: nothing may be sent while the reading stays 0
        cycles(50);

        tb_din = 8'h2E;
        wait_idle();

        tb_din = 8'h07;
        wait_idle();

        // two updates inside one frame: middle value is lost, last one follows back-to-back
        tb_din = 8'h10;
        cycles(12);
        tb_din = 8'h20;
        cycles(8);
        tb_din = 8'h30;
        wait_idle();

        // change lands on the exact stop-to-start edge of the no-parity instance
        tb_din = 8'h41;
        cycles(10);
        tb_din = 8'h42;
        wait_cycle_no(m_end[0] - 1);
        tb_din = 8'h43;
        wait_idle();

        // reset in the middle of data bit 3
        tb_din = 8'h5A;
        cycles(2);
        wait_cycle_no(m_end[0] - 10 * C + 4 * C + 1);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_tx", 0, 32'(if0.tx), 32'd1);
        check("rst_busy", 0, 32'(if0.busy), 32'd0);
        check("rst_tx", 1, 32'(if1.tx), 32'd1);
        check("rst_busy", 1, 32'(if1.busy), 32'd0);
        tb_din = 8'h00;
        cycles(3);
        #2 Reset_n = 1'b1;
        cycles(30);
        tb_din = 8'h99;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            tb_din = 8'($urandom_range(0, 255));
            cycles(int'($urandom_range(1, 60)));
        end
        wait_idle();

        cycles(5);
        check("leftover_frames", 0, 32'(q0.size()), 32'd0);
        check("leftover_frames", 1, 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
